// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the program counter and instruction register.
// Fetches the instruction at pc through a ready handshake, issues it to
// decode for one cycle, waits for execute to finish, then reloads pc from
// the branch-logic next-PC result. A HALT opcode parks the unit until reset.
module pc_fetch_unit #(
  parameter int unsigned          PC_W     = 9,
  parameter int unsigned          INSTR_W  = 16,
  parameter logic [PC_W-1:0]      RESET_PC = '0,
  parameter int unsigned          CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_ready,
  output logic               mem_rd,
  output logic [PC_W-1:0]    mem_addr,
  input  logic [PC_W-1:0]    br_logic,
  input  logic               ex_done,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  output logic               halted,
  output logic [CNT_W-1:0]   retire_cnt
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  // Top three opcode bits all set marks a HALT instruction.
  localparam logic [2:0] OP_HALT = 3'b111;

  logic [2:0] state;
  logic [2:0] state_nxt;

  logic       fetch_hit;
  logic       exec_done;
  logic       is_halt_op;

  assign fetch_hit  = (state == S_FETCH) && mem_ready;
  assign exec_done  = (state == S_EXEC) && ex_done;
  assign is_halt_op = (ir[INSTR_W-1 -: 3] == OP_HALT);

  // Next-state selection; inputs not relevant to the current state are ignored.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start)     state_nxt = S_FETCH;
      S_FETCH: if (mem_ready) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = is_halt_op ? S_HALT : S_EXEC;
      S_EXEC:  if (ex_done)   state_nxt = S_FETCH;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register; reset returns to IDLE without waiting for a clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Program counter: loaded from branch logic only when execute completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       pc <= RESET_PC;
    else if (exec_done) pc <= br_logic;
  end

  // Instruction register: captured only on the FETCH->ISSUE edge so it stays
  // stable through ISSUE, EXEC and HALT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       ir <= '0;
    else if (fetch_hit) ir <= mem_rdata;
  end

  // Retired-instruction counter, saturating at all-ones; HALT never retires.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      retire_cnt <= '0;
    else if (exec_done && (retire_cnt != '1))
      retire_cnt <= retire_cnt + CNT_W'(1);
  end

  // Outputs decode straight from state, so an asynchronous reset drops an
  // outstanding read request immediately.
  always_comb begin
    mem_rd   = (state == S_FETCH);
    ir_valid = (state == S_ISSUE);
    halted   = (state == S_HALT);
    mem_addr = pc;
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed testbench for pc_fetch_unit with a transaction-level model of
// pc / ir / retire count and expected handshake outputs per cycle.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        mem_rd;
  logic [8:0]  mem_addr;
  logic [8:0]  br_logic = '0;
  logic        ex_done = 1'b0;
  logic [8:0]  pc;
  logic [15:0] ir;
  logic        ir_valid;
  logic        halted;
  logic [15:0] retire_cnt;

  // Narrow-counter instance for the saturation check.
  logic        s_reset_n = 1'b1;
  logic        s_start = 1'b0;
  logic        s_mem_ready = 1'b0;
  logic        s_ex_done = 1'b0;
  logic        s_mem_rd;
  logic [8:0]  s_mem_addr;
  logic [8:0]  s_pc;
  logic [8:0]  s_br;
  logic [15:0] s_ir;
  logic        s_ir_valid;
  logic        s_halted;
  logic [3:0]  s_retire_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Model state.
  logic [8:0]  m_pc;
  logic [15:0] m_ir;
  logic [15:0] m_cnt;
  logic        e_rd, e_iv, e_h;
  logic        check_en = 1'b0;

  always #5 clk = ~clk;

  pc_fetch_unit #(.PC_W(9), .INSTR_W(16), .RESET_PC(9'd0), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .br_logic(br_logic), .ex_done(ex_done), .pc(pc), .ir(ir),
    .ir_valid(ir_valid), .halted(halted), .retire_cnt(retire_cnt)
  );

  pc_fetch_unit #(.PC_W(9), .INSTR_W(16), .RESET_PC(9'd0), .CNT_W(4)) dut4 (
    .clk(clk), .reset_n(s_reset_n), .start(s_start), .mem_rdata(16'h0001),
    .mem_ready(s_mem_ready), .mem_rd(s_mem_rd), .mem_addr(s_mem_addr),
    .br_logic(s_br), .ex_done(s_ex_done), .pc(s_pc), .ir(s_ir),
    .ir_valid(s_ir_valid), .halted(s_halted), .retire_cnt(s_retire_cnt)
  );

  assign s_br = s_pc + 9'd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("mem_rd", {31'd0, mem_rd}, {31'd0, e_rd});
      chk("ir_valid", {31'd0, ir_valid}, {31'd0, e_iv});
      chk("halted", {31'd0, halted}, {31'd0, e_h});
      chk("pc", {23'd0, pc}, {23'd0, m_pc});
      chk("mem_addr", {23'd0, mem_addr}, {23'd0, m_pc});
      chk("ir", {16'd0, ir}, {16'd0, m_ir});
      chk("retire_cnt", {16'd0, retire_cnt}, {16'd0, m_cnt});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_phase(input logic rd, input logic iv, input logic h);
    e_rd = rd; e_iv = iv; e_h = h;
  endtask

  task automatic model_reset();
    m_pc = 9'd0; m_ir = '0; m_cnt = '0;
    expect_phase(1'b0, 1'b0, 1'b0);
  endtask

  // Entered in the first FETCH cycle; returns in the next FETCH cycle, or in HALT.
  task automatic run_instr(input int waits, input logic [15:0] data, input int ex_wait,
                           input logic [8:0] next, input logic spurious);
    for (int i = 0; i < waits; i++) begin
      mem_ready = 1'b0;
      mem_rdata = 16'($urandom);
      ex_done   = spurious;
      br_logic  = 9'($urandom);
      tick();
      expect_phase(1'b1, 1'b0, 1'b0);
    end
    ex_done   = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = data;
    tick();
    mem_ready = 1'b0;
    mem_rdata = 16'($urandom);
    m_ir = data;
    expect_phase(1'b0, 1'b1, 1'b0);
    tick();
    if (data[15:13] == 3'b111) begin
      expect_phase(1'b0, 1'b0, 1'b1);
      return;
    end
    expect_phase(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < ex_wait; i++) begin
      mem_ready = 1'b1;
      tick();
    end
    mem_ready = 1'b0;
    ex_done   = 1'b1;
    br_logic  = next;
    tick();
    ex_done  = 1'b0;
    br_logic = 9'($urandom);
    m_pc = next;
    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    expect_phase(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    check_en = 1'b1;
    #1;
    reset_n = 1'b0;
    s_reset_n = 1'b0;
    #1;
    chk("rst_pc", {23'd0, pc}, 32'd0);
    chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst_ir", {16'd0, ir}, 32'd0);
    chk("rst_cnt", {16'd0, retire_cnt}, 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    s_reset_n = 1'b1;
    tick();

    // First instruction, immediate ready.
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_phase(1'b1, 1'b0, 1'b0);
    run_instr(0, 16'hA123, 0, 9'd1, 1'b0);
    chk("first_ir", {16'd0, ir}, 32'h0000A123);
    chk("first_pc", {23'd0, pc}, 32'd1);
    chk("first_cnt", {16'd0, retire_cnt}, 32'd1);
    chk("first_addr", {23'd0, mem_addr}, 32'd1);

    // Wait states with spurious ex_done, then branches and wrap.
    run_instr(4, 16'h1234, 2, 9'd10, 1'b1);
    chk("pc_10", {23'd0, pc}, 32'd10);
    run_instr(0, 16'h2222, 0, 9'd3, 1'b0);
    chk("branch_addr", {23'd0, mem_addr}, 32'd3);
    run_instr(1, 16'h3333, 0, 9'd511, 1'b0);
    run_instr(0, 16'h4444, 1, 9'd0, 1'b0);
    chk("wrap_addr", {23'd0, mem_addr}, 32'd0);
    chk("cnt_5", {16'd0, retire_cnt}, 32'd5);

    // Reset asserted between edges while a read is outstanding.
    run_instr(0, 16'h5555, 0, 9'd77, 1'b0);
    chk("pre_rst_rd", {31'd0, mem_rd}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rd", {31'd0, mem_rd}, 32'd0);
    chk("async_pc", {23'd0, pc}, 32'd0);
    model_reset();
    tick();
    mem_ready = 1'b1;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    mem_ready = 1'b0;
    chk("idle_after_rst", {31'd0, mem_rd}, 32'd0);

    // One retired instruction, then HALT.
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_phase(1'b1, 1'b0, 1'b0);
    run_instr(0, 16'h0042, 0, 9'd7, 1'b0);
    run_instr(2, 16'hE000, 0, 9'd0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      start = 1'b1; ex_done = 1'b1; mem_ready = 1'b1;
      br_logic = 9'($urandom);
      tick();
    end
    start = 1'b0; ex_done = 1'b0; mem_ready = 1'b0;
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_cnt", {16'd0, retire_cnt}, 32'd1);
    chk("halt_pc", {23'd0, pc}, 32'd7);
    chk("halt_ir", {16'd0, ir}, 32'h0000E000);
    check_en = 1'b0;

    // Saturation on the 4-bit counter build: 3 cycles per instruction.
    s_mem_ready = 1'b1;
    s_ex_done = 1'b1;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick(); tick(); tick();
      chk("sat_cnt", {28'd0, s_retire_cnt}, (i < 15) ? 32'(i) : 32'd15);
    end
    chk("sat_final", {28'd0, s_retire_cnt}, 32'hF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Owns the program counter and instruction register for the simple RISC machine.
- Fetches the instruction at PC from instruction memory through a ready handshake, then issues it to decode.
- Waits for the execute stage to finish, then loads PC from the branch-logic next-PC result.
- Sits directly downstream of the branch-logic block: it consumes br_logic and supplies the current PC that branch logic adds to.

Parameters:
PC_W, 9, program counter / memory address width
INSTR_W, 16, instruction width
RESET_PC, 9'd0, PC value loaded at reset
CNT_W, 16, retired-instruction counter width

Ports:
clk  in  1  system clock, rising-edge
reset_n  in  1  asynchronous active-low reset
start  in  1  begin fetching; honoured only in IDLE
mem_rdata  in  INSTR_W  instruction word from memory
mem_ready  in  1  memory data valid this cycle
mem_rd  out  1  memory read request
mem_addr  out  PC_W  memory read address (= pc)
br_logic  in  PC_W  next PC from branch logic
ex_done  in  1  execute stage finished current instruction
pc  out  PC_W  current instruction address, fed to branch logic
ir  out  INSTR_W  instruction register
ir_valid  out  1  one-cycle pulse: ir holds a new instruction
halted  out  1  HALT instruction reached
retire_cnt  out  CNT_W  instructions retired, saturating

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous, active-low.
- While reset_n=0:
  - State forced to IDLE.
  - pc=RESET_PC, ir=0, retire_cnt=0.
  - mem_rd=0, ir_valid=0, halted=0.
  - All take effect immediately, without waiting for a clock edge.
- States: IDLE, FETCH, ISSUE, EXEC, HALT. Every transition happens on a rising clk edge.
- IDLE:
  - mem_rd=0.
  - start=1 → FETCH.
- FETCH:
  - mem_rd=1 and mem_addr=pc, held stable until mem_ready.
  - mem_ready=1 in the same cycle: ir<=mem_rdata, → ISSUE.
  - Otherwise remain in FETCH; there is no timeout.
  - The earliest possible fetch takes 1 cycle.
- ISSUE:
  - ir_valid=1 for exactly this one cycle; mem_rd=0.
  - ir[15:13]==3'b111 (HALT) → HALT.
  - Otherwise → EXEC.
- EXEC:
  - Wait for ex_done=1. On that edge: pc<=br_logic, retire_cnt increments, → FETCH.
  - br_logic is sampled only on this edge; it must be valid whenever ex_done=1.
- HALT:
  - halted=1 and mem_rd=0.
  - pc and ir are held; retire_cnt is unchanged (HALT is not counted).
  - Exit only by reset.
- Ignored inputs:
  - mem_ready outside FETCH.
  - ex_done outside EXEC.
  - start outside IDLE.
- Widths and wrap:
  - pc is exactly PC_W bits. Wrap-around comes from br_logic (e.g. 511+1 → 0); the block performs no extra arithmetic on PC.
  - retire_cnt saturates at all-ones and does not wrap.
- Throughput: minimum 3 cycles per instruction (FETCH with immediate ready, ISSUE, EXEC with immediate ex_done).
- Reset mid-operation:
  - An outstanding read is abandoned: mem_rd deasserts asynchronously.
  - A late mem_ready after reset is ignored, because the state is IDLE.
- ir stability: ir changes only on the FETCH→ISSUE edge, so it is stable throughout EXEC for decode/datapath use.

Test Plan:
- Reset then start, memory ready immediately, mem_rdata=16'hA123:
  - FETCH at addr 0 for 1 cycle.
  - ir=16'hA123 and ir_valid high for exactly 1 cycle.
  - EXEC entered.
  - ex_done with br_logic=9'd1 → pc=1, retire_cnt=1, FETCH at addr 1.
- Memory wait states, mem_ready held low 4 cycles:
  - mem_rd=1 and mem_addr=pc stable for all 5 FETCH cycles.
  - ir loads only on the ready cycle.
  - A spurious ex_done during FETCH leaves pc unchanged.
- Taken branch:
  - In EXEC at pc=9'd10, drive br_logic=9'd3 with ex_done → next fetch address 3.
  - Repeat with br_logic=9'd0 after pc=9'd511 → fetch address 0.
- HALT:
  - mem_rdata=16'hE000 → ISSUE then HALT, halted=1, mem_rd=0 for 20 cycles.
  - start and ex_done ignored.
  - retire_cnt unchanged.
- Asynchronous reset asserted mid-FETCH (between clock edges):
  - mem_rd=0 and pc=RESET_PC immediately.
  - A late mem_ready=1 after release is ignored; state stays IDLE until start.
- Counter saturation:
  - Force retire_cnt near max (CNT_W=4 build) and retire 20 instructions → retire_cnt holds 4'hF.
